// File: rtl/funnel_pkg.sv
// rtl/funnel_pkg.sv - shared constants, width helper and output word type for the buffered funnel
package funnel_pkg;

  localparam int FUNNEL_RR   = 0;
  localparam int FUNNEL_PRIO = 1;

  localparam int DEF_IDX_W      = 2;
  localparam int DEF_DATA_WIDTH = 32;

  function automatic int idx_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  // Tagged output word for the default 4x32 configuration.
  typedef struct packed {
    logic [DEF_IDX_W-1:0]      tag;
    logic [DEF_DATA_WIDTH-1:0] data;
  } funnel_word_t;

endpackage

// File: rtl/funnel_buffered_multi_if.sv
// rtl/funnel_buffered_multi_if.sv - per-channel enqueue side plus tagged output stream of the funnel
interface funnel_buffered_multi_if #(
  parameter int NCHAN      = 4,
  parameter int DATA_WIDTH = 32
);
  import funnel_pkg::*;

  localparam int IDX_W = idx_w(NCHAN);

  logic [NCHAN-1:0]            in_enq_ena;
  logic [NCHAN*DATA_WIDTH-1:0] in_enq_v;
  logic [NCHAN-1:0]            in_enq_rdy;
  logic                        out_enq_ena;
  logic [IDX_W+DATA_WIDTH-1:0] out_enq_v;
  logic                        out_enq_rdy;

  modport slave (
    input  in_enq_ena, in_enq_v, out_enq_rdy,
    output in_enq_rdy, out_enq_ena, out_enq_v
  );

  modport master (
    output in_enq_ena, in_enq_v, out_enq_rdy,
    input  in_enq_rdy, out_enq_ena, out_enq_v
  );
endinterface

// File: rtl/funnel_buffered_multi_fifo.sv
// rtl/funnel_buffered_multi_fifo.sv - DEPTH-entry circular FIFO, one per funnel channel
module fifo_p_depth #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enq,
  input  logic [DATA_WIDTH-1:0] enq_data,
  input  logic                  deq,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic [AW:0]           count;
  logic                  wr;
  logic                  rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr    = enq && !full;
  assign rd    = deq && !empty;
  // Head is forced to zero when empty so unwritten storage never leaks out.
  assign head  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      if (wr && !rd)      count <= count + 1'b1;
      else if (!wr && rd) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= enq_data;
  end

endmodule

// File: rtl/funnel_buffered_multi.sv
// rtl/funnel_buffered_multi.sv - N-channel buffered funnel: per-channel FIFOs drained by an RR/priority
// arbiter with grant locking onto one tagged output stream
module funnel_buffered_multi
  import funnel_pkg::*;
#(
  parameter int NCHAN      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int MODE       = FUNNEL_RR
) (
  input  logic                    clk,
  input  logic                    rst,
  funnel_buffered_multi_if.slave  bus
);
  localparam int IDX_W = idx_w(NCHAN);

  logic [NCHAN-1:0]      full;
  logic [NCHAN-1:0]      empty;
  logic [NCHAN-1:0]      pop;
  logic [DATA_WIDTH-1:0] head [NCHAN];
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      lock_idx;
  logic [IDX_W-1:0]      search_idx;
  logic [IDX_W-1:0]      grant;
  logic                  locked;
  logic                  any_valid;
  logic                  xfer;

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    fifo_p_depth #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .enq     (bus.in_enq_ena[c]),
      .enq_data(bus.in_enq_v[c*DATA_WIDTH +: DATA_WIDTH]),
      .deq     (pop[c]),
      .full    (full[c]),
      .empty   (empty[c]),
      .head    (head[c])
    );
    assign pop[c] = xfer && (grant == IDX_W'(c));
  end

  always_comb begin
    logic       found;
    int         j;
    logic [IDX_W-1:0] k;
    found      = 1'b0;
    j          = 0;
    k          = '0;
    search_idx = '0;
    if (MODE == FUNNEL_PRIO) begin
      for (int i = 0; i < NCHAN; i++) begin
        k = IDX_W'(i);
        if (!found && !empty[k]) begin
          search_idx = k;
          found      = 1'b1;
        end
      end
    end else begin
      // Round-robin: scan starts one past the last granted channel and wraps.
      for (int i = 1; i <= NCHAN; i++) begin
        j = int'(rr_ptr) + i;
        if (j >= NCHAN) j = j - NCHAN;
        k = IDX_W'(j);
        if (!found && !empty[k]) begin
          search_idx = k;
          found      = 1'b1;
        end
      end
    end
  end

  assign grant           = locked ? lock_idx : search_idx;
  assign any_valid       = ~&empty;
  assign xfer            = any_valid && bus.out_enq_rdy;
  assign bus.in_enq_rdy  = rst ? '0 : ~full;
  assign bus.out_enq_ena = any_valid;
  assign bus.out_enq_v   = any_valid ? {grant, head[grant]} : '0;

  // A stalled offer freezes the grant until it transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= IDX_W'(NCHAN - 1);
      locked   <= 1'b0;
      lock_idx <= '0;
    end else if (xfer) begin
      rr_ptr   <= grant;
      locked   <= 1'b0;
    end else if (any_valid) begin
      locked   <= 1'b1;
      lock_idx <= grant;
    end
  end

endmodule

// File: tb/tb_funnel_buffered_multi.sv
// tb/tb_funnel_buffered_multi.sv - bench for funnel_buffered_multi: RR and PRIO instances driven in
// parallel against a queue-based reference model, plus a directed vector table and corner sequences
module tb_funnel_buffered_multi;
  import funnel_pkg::*;

  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int DEP = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  funnel_buffered_multi_if #(.NCHAN(NCH), .DATA_WIDTH(DW)) bus_rr ();
  funnel_buffered_multi_if #(.NCHAN(NCH), .DATA_WIDTH(DW)) bus_pr ();

  funnel_buffered_multi #(.NCHAN(NCH), .DATA_WIDTH(DW), .DEPTH(DEP), .MODE(FUNNEL_RR)) dut_rr (
    .clk(clk), .rst(rst), .bus(bus_rr.slave)
  );
  funnel_buffered_multi #(.NCHAN(NCH), .DATA_WIDTH(DW), .DEPTH(DEP), .MODE(FUNNEL_PRIO)) dut_pr (
    .clk(clk), .rst(rst), .bus(bus_pr.slave)
  );

  int checks = 0;
  int fails  = 0;
  int viol   = 0;
  bit count_viol = 1'b0;

  // Reference model: index 0 = round-robin instance, 1 = priority instance.
  logic [DW-1:0] mq [2][NCH][$];
  int            m_rr [2];
  bit            m_lk [2];
  int            m_lc [2];

  logic [3:0]  cur_ena;
  logic [31:0] cur_base;
  logic        cur_ordy;

  typedef struct {
    logic [3:0]  ena;
    logic [31:0] base;
    logic        ordy;
    logic [3:0]  rdy;
    logic        oena;
    logic [33:0] ov;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < NCH; c++) mq[m][c].delete();
      m_rr[m] = NCH - 1;
      m_lk[m] = 1'b0;
      m_lc[m] = 0;
    end
  endfunction

  function automatic int model_grant(input int m);
    if (m_lk[m]) return m_lc[m];
    if (m == 0) begin
      for (int i = 1; i <= NCH; i++)
        if (mq[m][(m_rr[m] + i) % NCH].size() != 0) return (m_rr[m] + i) % NCH;
    end else begin
      for (int c = 0; c < NCH; c++)
        if (mq[m][c].size() != 0) return c;
    end
    return -1;
  endfunction

  task automatic model_check();
    for (int m = 0; m < 2; m++) begin
      int          g;
      logic [1:0]  tag;
      logic        exp_ena;
      logic [33:0] exp_v;
      logic [3:0]  exp_rdy;
      logic [3:0]  act_rdy;
      logic        act_ena;
      logic [33:0] act_v;
      string       nm;
      g       = rst ? -1 : model_grant(m);
      tag     = 2'(g);
      exp_ena = (g >= 0);
      exp_v   = (g >= 0) ? {tag, mq[m][g][0]} : 34'd0;
      for (int c = 0; c < NCH; c++) exp_rdy[c] = !rst && (mq[m][c].size() < DEP);
      act_rdy = (m == 0) ? bus_rr.in_enq_rdy  : bus_pr.in_enq_rdy;
      act_ena = (m == 0) ? bus_rr.out_enq_ena : bus_pr.out_enq_ena;
      act_v   = (m == 0) ? bus_rr.out_enq_v   : bus_pr.out_enq_v;
      nm      = (m == 0) ? "rr" : "pr";
      check({nm, "_model_rdy"}, 64'(act_rdy), 64'(exp_rdy));
      check({nm, "_model_ena"}, 64'(act_ena), 64'(exp_ena));
      check({nm, "_model_v"},   64'(act_v),   64'(exp_v));
    end
  endtask

  function automatic void model_update();
    if (rst) begin
      model_clear();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      int g;
      int pre [NCH];
      for (int c = 0; c < NCH; c++) pre[c] = mq[m][c].size();
      g = model_grant(m);
      if (g >= 0) begin
        if (cur_ordy) begin
          void'(mq[m][g].pop_front());
          m_rr[m] = g;
          m_lk[m] = 1'b0;
        end else begin
          m_lk[m] = 1'b1;
          m_lc[m] = g;
        end
      end
      for (int c = 0; c < NCH; c++)
        if (cur_ena[c] && pre[c] < DEP) mq[m][c].push_back(cur_base + 32'(c));
    end
  endfunction

  task automatic drive(input logic [3:0] ena, input logic [31:0] base, input logic ordy);
    cur_ena  = ena;
    cur_base = base;
    cur_ordy = ordy;
    bus_rr.in_enq_ena  = ena;
    bus_pr.in_enq_ena  = ena;
    bus_rr.in_enq_v    = {base + 32'd3, base + 32'd2, base + 32'd1, base};
    bus_pr.in_enq_v    = {base + 32'd3, base + 32'd2, base + 32'd1, base};
    bus_rr.out_enq_rdy = ordy;
    bus_pr.out_enq_rdy = ordy;
    #1;
    model_check();
    if (count_viol && !rst) begin
      for (int c = 0; c < NCH; c++) begin
        if (ena[c] && !bus_rr.in_enq_rdy[c]) begin
          viol++;
          $display("protocol note: enqueue on full channel %0d ignored", c);
        end
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic rst_seq(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      drive(cur_ena, cur_base, cur_ordy);
      advance();
    end
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic [3:0] ena, input logic [31:0] base, input logic ordy,
                              input logic [3:0] rdy, input logic oena, input logic [33:0] ov);
    vec_t v;
    v.ena = ena; v.base = base; v.ordy = ordy; v.rdy = rdy; v.oena = oena; v.ov = ov;
    return v;
  endfunction

  initial begin
    int n;
    model_clear();
    cur_ena = '0; cur_base = '0; cur_ordy = 1'b0;
    @(negedge clk);
    rst_seq(3);

    // Directed table on the RR instance from a fresh reset (rr_ptr starts at 3).
    tbl[0]  = mk(4'b0001, 32'h100, 1'b1, 4'b1111, 1'b0, 34'd0);
    tbl[1]  = mk(4'b0110, 32'h200, 1'b0, 4'b1111, 1'b1, {2'd0, 32'h100});
    tbl[2]  = mk(4'b0000, 32'h0,   1'b1, 4'b1111, 1'b1, {2'd0, 32'h100});
    tbl[3]  = mk(4'b1000, 32'h300, 1'b1, 4'b1111, 1'b1, {2'd1, 32'h201});
    tbl[4]  = mk(4'b0000, 32'h0,   1'b1, 4'b1111, 1'b1, {2'd2, 32'h202});
    tbl[5]  = mk(4'b1000, 32'h400, 1'b1, 4'b1111, 1'b1, {2'd3, 32'h303});
    tbl[6]  = mk(4'b0000, 32'h0,   1'b1, 4'b1111, 1'b1, {2'd3, 32'h403});
    tbl[7]  = mk(4'b0010, 32'h500, 1'b0, 4'b1111, 1'b0, 34'd0);
    tbl[8]  = mk(4'b0010, 32'h600, 1'b0, 4'b1111, 1'b1, {2'd1, 32'h501});
    tbl[9]  = mk(4'b0010, 32'h700, 1'b0, 4'b1101, 1'b1, {2'd1, 32'h501});
    tbl[10] = mk(4'b0000, 32'h0,   1'b1, 4'b1101, 1'b1, {2'd1, 32'h501});
    tbl[11] = mk(4'b0000, 32'h0,   1'b1, 4'b1111, 1'b1, {2'd1, 32'h601});
    tbl[12] = mk(4'b0000, 32'h0,   1'b1, 4'b1111, 1'b0, 34'd0);
    count_viol = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].ena, tbl[i].base, tbl[i].ordy);
      check($sformatf("tbl%0d_rdy", i), 64'(bus_rr.in_enq_rdy),  64'(tbl[i].rdy));
      check($sformatf("tbl%0d_ena", i), 64'(bus_rr.out_enq_ena), 64'(tbl[i].oena));
      check($sformatf("tbl%0d_v", i),   64'(bus_rr.out_enq_v),   64'(tbl[i].ov));
      advance();
    end
    count_viol = 1'b0;
    check("full_push_violations", 64'(viol), 64'd1);

    // Round-robin fairness with every channel kept loaded.
    rst_seq(2);
    for (int k = 0; k < 10; k++) begin
      drive(4'hF, 32'h1000 + 32'(k * 16), 1'b1);
      if (k >= 1) begin
        check($sformatf("rr_fair_tag%0d", k), 64'(bus_rr.out_enq_v[33:32]), 64'((k - 1) % 4));
        check($sformatf("rr_fair_ena%0d", k), 64'(bus_rr.out_enq_ena), 64'd1);
      end
      advance();
    end

    // Reset in the middle of traffic; nothing buffered survives.
    cur_ena = 4'hF;
    rst_seq(3);
    drive(4'h0, 32'h0, 1'b0);
    check("post_rst_rdy", 64'(bus_rr.in_enq_rdy), 64'hF);
    check("post_rst_ena", 64'(bus_rr.out_enq_ena), 64'd0);
    check("post_rst_v",   64'(bus_rr.out_enq_v), 64'd0);
    advance();

    // Backpressure: ch0 offer holds while ch2 waits behind it.
    rst_seq(2);
    drive(4'b0001, 32'hA5, 1'b0);
    advance();
    drive(4'b0100, 32'h75, 1'b0);
    check("bp_hold0", 64'(bus_rr.out_enq_v), 64'({2'd0, 32'hA5}));
    advance();
    for (int k = 1; k < 5; k++) begin
      drive(4'b0000, 32'h0, 1'b0);
      check($sformatf("bp_hold%0d", k), 64'(bus_rr.out_enq_v), 64'({2'd0, 32'hA5}));
      advance();
    end
    drive(4'b0000, 32'h0, 1'b1);
    check("bp_release", 64'(bus_rr.out_enq_v), 64'({2'd0, 32'hA5}));
    advance();
    drive(4'b0000, 32'h0, 1'b1);
    check("bp_next_ch2", 64'(bus_rr.out_enq_v), 64'({2'd2, 32'h77}));
    advance();

    // Priority mode: a stalled ch3 offer is not preempted, then ch0 dominates.
    rst_seq(2);
    drive(4'b1000, 32'h30, 1'b0);
    advance();
    drive(4'b0001, 32'h10, 1'b0);
    check("pr_lock0", 64'(bus_pr.out_enq_v), 64'({2'd3, 32'h33}));
    advance();
    drive(4'b0001, 32'h11, 1'b0);
    check("pr_lock1", 64'(bus_pr.out_enq_v), 64'({2'd3, 32'h33}));
    advance();
    drive(4'b1000, 32'h40, 1'b1);
    check("pr_lock_xfer", 64'(bus_pr.out_enq_v), 64'({2'd3, 32'h33}));
    advance();
    for (int k = 0; k < 6; k++) begin
      drive(4'b0001, 32'h50 + 32'(k), 1'b1);
      check($sformatf("pr_ch0_wins%0d", k), 64'(bus_pr.out_enq_v[33:32]), 64'd0);
      advance();
    end
    n = 0;
    drive(4'b0000, 32'h0, 1'b1);
    while (bus_pr.out_enq_ena && bus_pr.out_enq_v[33:32] == 2'd0 && n < 8) begin
      advance();
      drive(4'b0000, 32'h0, 1'b1);
      n++;
    end
    check("pr_ch3_after_ch0", 64'(bus_pr.out_enq_v), 64'({2'd3, 32'h43}));
    advance();

    // Randomised traffic against the model, with occasional resets.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(199) == 0) rst_seq(2);
      drive(4'($urandom), $urandom, ($urandom_range(3) != 0));
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
